// File: rtl/nios_mul_pkg.sv
// Shared definitions for the pipelined Nios II-style multiply unit.
//   mode_t     : operation select (low word, or high word with operand signedness)
//   sign_t     : signedness of src1/src2 for a mode
//   NUM_SLICES : partial-product slices per operand at the default widths
package nios_mul_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PART_W = 16;
  localparam int DEF_TAG_W  = 5;
  localparam int NUM_SLICES = DEF_DATA_W / DEF_PART_W;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'd0,  // low word; signedness irrelevant
    MODE_MULXSS = 2'd1,  // high word, signed x signed
    MODE_MULXSU = 2'd2,  // high word, signed x unsigned
    MODE_MULXUU = 2'd3   // high word, unsigned x unsigned
  } mode_t;

  typedef struct packed {
    logic src1;
    logic src2;
  } sign_t;

  // MUL is treated as unsigned: the low product word does not depend on it.
  function automatic sign_t mode_sign(mode_t mode);
    sign_t s;
    s.src1 = (mode == MODE_MULXSS) || (mode == MODE_MULXSU);
    s.src2 = (mode == MODE_MULXSS);
    return s;
  endfunction

endpackage

// File: rtl/nios_mul_slice.sv
// Registered PART_W x PART_W unsigned multiplier with clock enable; one DSP
// block's worth of work.
//   clk, reset : clock, asynchronous active-high reset
//   ce         : load enable (low holds the product)
//   a, b       : unsigned operand slices
//   p          : registered full-width product
module nios_mul_slice #(
  parameter int PART_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [PART_W-1:0]   a,
  input  logic [PART_W-1:0]   b,
  output logic [2*PART_W-1:0] p
);

  // NOTE: data registers are reset as well as valid bits so the unit's
  // outputs are deterministic from reset; cost is a reset net per flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (ce) begin
      // NOTE: state is written with non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      p <= {{PART_W{1'b0}}, a} * {{PART_W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/nios_mul_pipe.sv
// Three-stage pipelined integer multiply unit with valid/ready flow control,
// global stall, synchronous flush and a pass-through tag.
//   S1: operands extended to DATA_W+1 bits according to mode signedness
//   S2: all unsigned partial products (DSP slices) plus sign-correction terms
//   S3: summation and result-word selection; drives the outputs
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   flush                : kills every in-flight op at the next edge
//   in_valid/in_ready    : operation handshake; in_ready = !stall
//   in_mode              : mode_t encoding
//   in_src1, in_src2     : operands
//   in_tag               : opaque tag returned with the result
//   out_valid/out_ready  : result handshake
//   out_result, out_tag  : selected product word and its tag
module nios_mul_pipe
  import nios_mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PART_W = DEF_PART_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  // Derived from the instance parameters, so it tracks overrides of DATA_W
  // and PART_W (the package constant covers the default widths only).
  localparam int N      = DATA_W / PART_W;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic [PROD_W-1:0] prod_t;

  logic stall;
  logic s1_valid, s2_valid, s3_valid;

  // Global stall: the whole pipe freezes while S3 holds an unconsumed result.
  assign stall     = s3_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = s3_valid;

  // ---------------------------------------------------------------- S1
  mode_t              in_mode_e;
  sign_t              in_sign;
  logic [DATA_W:0]    s1_a, s1_b;
  mode_t              s1_mode;
  logic [TAG_W-1:0]   s1_tag;

  assign in_mode_e = mode_t'(in_mode);
  assign in_sign   = mode_sign(in_mode_e);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_MUL;
      s1_tag   <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (!stall) s1_valid <= in_valid;
      if (!stall) begin
        s1_a    <= {in_sign.src1 & in_src1[DATA_W-1], in_src1};
        s1_b    <= {in_sign.src2 & in_src2[DATA_W-1], in_src2};
        s1_mode <= in_mode_e;
        s1_tag  <= in_tag;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  // With A = -ax*2^W + A_lo and B = -bx*2^W + B_lo, the product modulo 2^(2W)
  // is A_lo*B_lo - (ax*B_lo + bx*A_lo)*2^W; the ax*bx*2^(2W) term vanishes.
  logic [2*PART_W-1:0] s2_pp [N*N];
  logic [DATA_W-1:0]   s2_corr_a, s2_corr_b;
  mode_t               s2_mode;
  logic [TAG_W-1:0]    s2_tag;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      nios_mul_slice #(.PART_W(PART_W)) u_slice (
        .clk   (clk),
        .reset (reset),
        .ce    (!stall),
        .a     (s1_a[i*PART_W +: PART_W]),
        .b     (s1_b[j*PART_W +: PART_W]),
        .p     (s2_pp[i*N+j])
      );
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_corr_a <= '0;
      s2_corr_b <= '0;
      s2_mode   <= MODE_MUL;
      s2_tag    <= '0;
    end else begin
      if (flush)       s2_valid <= 1'b0;
      else if (!stall) s2_valid <= s1_valid;
      if (!stall) begin
        s2_corr_a <= s1_a[DATA_W] ? s1_b[DATA_W-1:0] : '0;
        s2_corr_b <= s1_b[DATA_W] ? s1_a[DATA_W-1:0] : '0;
        s2_mode   <= s1_mode;
        s2_tag    <= s1_tag;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  prod_t prod;

  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; a path that left prod unassigned would infer a latch.
    prod = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod = prod + (prod_t'(s2_pp[i*N+j]) << (PART_W * (i + j)));
      end
    end
    prod = prod - ((prod_t'(s2_corr_a) + prod_t'(s2_corr_b)) << DATA_W);
  end

  logic [DATA_W-1:0] s3_result;
  logic [TAG_W-1:0]  s3_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid  <= 1'b0;
      s3_result <= '0;
      s3_tag    <= '0;
    end else begin
      if (flush)       s3_valid <= 1'b0;
      else if (!stall) s3_valid <= s2_valid;
      if (!stall) begin
        s3_result <= (s2_mode == MODE_MUL) ? prod[DATA_W-1:0] : prod[PROD_W-1:DATA_W];
        s3_tag    <= s2_tag;
      end
    end
  end

  assign out_result = s3_result;
  assign out_tag    = s3_tag;

endmodule

// File: tb/tb_nios_mul_pipe.sv
// Self-checking bench for nios_mul_pipe: constant vector table, random
// streams with and without backpressure, flush and async-reset sequences.
// A negedge scoreboard checks value, tag, order, latency and hold stability.
module tb_nios_mul_pipe;
  import nios_mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  nios_mul_pipe #(.DATA_W(32), .PART_W(16), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent 64-bit reference product.
  function automatic logic [31:0] ref_mul(mode_t m, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (m == MODE_MULXSS || m == MODE_MULXSU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (m == MODE_MULXSS) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (m == MODE_MUL) ? p[31:0] : p[63:32];
  endfunction

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  logic [31:0] drv_exp;
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          hold_valid = 0;
  logic [31:0] hold_res;
  logic [4:0]  hold_tag;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
      hold_valid = 0;
    end else begin
      if (hold_valid && out_valid) begin
        check("hold_result", out_result, hold_res);
        check("hold_tag", out_tag, hold_tag);
      end
      hold_valid = out_valid && !out_ready;
      hold_res   = out_result;
      hold_tag   = out_tag;
      if (out_valid && out_ready) begin
        check("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("result", out_result, e.res);
          check("tag", out_tag, e.tag);
          check("latency", cyc - e.cyc, 3 + stall_cnt - e.stalls);
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{drv_exp, in_tag, cyc, stall_cnt});
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input mode_t m, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
    in_valid = v;
    in_mode  = m;
    in_src1  = a;
    in_src2  = b;
    in_tag   = t;
    drv_exp  = exp;
  endtask

  task automatic drive_ref(input mode_t m, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t);
    drive(1'b1, m, a, b, t, ref_mul(m, a, b));
  endtask

  task automatic wait_idle();
    int g = 0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && g < 40) begin
      tick();
      g++;
    end
    check("drain", q.size(), 0);
  endtask

  // Random stream of n ops; optionally drops out_ready for stall_len cycles
  // once the first result shows up.
  task automatic stream(input int n, input int stall_len, input logic [4:0] tag0);
    int          k = 0;
    int          left = 0;
    int          guard = 0;
    bit          done_stall = 0;
    mode_t       m;
    logic [31:0] a, b;
    m = mode_t'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    while (k < n && guard < 100) begin
      tick();
      if (!done_stall && stall_len > 0 && out_valid) begin
        done_stall = 1;
        left       = stall_len;
      end
      out_ready = (left == 0);
      drive_ref(m, a, b, tag0 + 5'(k));
      @(negedge clk);
      if (left > 0) begin
        check("stall_in_ready", in_ready, 0);
        left--;
      end
      if (in_ready) begin
        k++;
        m = mode_t'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
      end
      guard++;
    end
    check("stream_issued", k, n);
    if (stall_len == 0) check("b2b_cycles", guard, n);
    wait_idle();
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    mode_t       mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MODE_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[1]  = '{MODE_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{MODE_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{MODE_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{MODE_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5]  = '{MODE_MULXUU, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[6]  = '{MODE_MUL,    32'h80000000, 32'h80000000, 32'h00000000};
    vecs[7]  = '{MODE_MULXSS, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[8]  = '{MODE_MULXSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{MODE_MULXSS, 32'h00000000, 32'h80000000, 32'h00000000};
    vecs[10] = '{MODE_MUL,    32'h00000003, 32'h00000005, 32'h0000000F};
    vecs[11] = '{MODE_MULXSS, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[12] = '{MODE_MULXUU, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[13] = '{MODE_MULXSU, 32'h00000002, 32'h80000000, 32'h00000001};

    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, MODE_MUL, 32'd0, 32'd0, 5'd0, 32'd0);

    // Reset state, during and after reset.
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_result", out_result, 0);
    check("post_rst_out_tag", out_tag, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Single ops from the constant table.
    for (int i = 0; i < 14; i++) begin
      tick();
      drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, 5'(i), vecs[i].exp);
      wait_idle();
    end

    // Back-to-back throughput, tags 0..7.
    stream(8, 0, 5'd0);

    // Backpressure: 5-cycle stall after the first result.
    stream(8, 5, 5'd8);

    // Flush with three ops in flight; op 13 issued the cycle after.
    tick(); drive_ref(MODE_MULXSS, 32'h12345678, 32'h9ABCDEF0, 5'd10);
    tick(); drive_ref(MODE_MULXUU, 32'hDEADBEEF, 32'hCAFEBABE, 5'd11);
    tick(); drive_ref(MODE_MUL,    32'h0000FFFF, 32'h0000FFFF, 5'd12);
    flush = 1'b1;
    tick(); flush = 1'b0;
    drive_ref(MODE_MULXSU, 32'h80000001, 32'hF0000000, 5'd13);
    @(negedge clk); check("flush_gap0", out_valid, 0);
    tick(); in_valid = 1'b0;
    @(negedge clk); check("flush_gap1", out_valid, 0);
    tick();
    @(negedge clk); check("flush_gap2", out_valid, 0);
    tick();
    @(negedge clk);
    check("post_flush_valid", out_valid, 1);
    check("post_flush_tag", out_tag, 13);
    wait_idle();

    // Flush in the cycle a result retires: that result is still delivered.
    tick(); drive_ref(MODE_MULXSS, 32'hFFFF0000, 32'h00010001, 5'd20);
    tick(); drive_ref(MODE_MUL,    32'h00000007, 32'h00000009, 5'd21);
    tick(); in_valid = 1'b0;
    tick(); flush = 1'b1;
    @(negedge clk); check("retire_in_flush", out_valid, 1);
    tick(); flush = 1'b0;
    @(negedge clk); check("after_retire_flush", out_valid, 0);
    wait_idle();

    // Asynchronous reset with S1..S3 full.
    tick(); drive_ref(MODE_MULXUU, 32'h11111111, 32'h22222222, 5'd30);
    tick(); drive_ref(MODE_MULXSS, 32'h33333333, 32'h44444444, 5'd31);
    tick(); drive_ref(MODE_MULXSU, 32'h55555555, 32'h66666666, 5'd32);
    tick(); in_valid = 1'b0;
    #2;
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    check("rst_release_in_ready", in_ready, 1);
    drive_ref(MODE_MULXSS, 32'h80000000, 32'h7FFFFFFF, 5'd31);
    wait_idle();

    // Final random stream after reset.
    stream(6, 2, 5'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
